// File: rtl/score_pkg.sv
// Shared types for the packed-BCD score counter.
// State encoding, BCD digit type and the bonus clamp helper.
package score_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_OVER
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  function automatic bcd_t bcd_clamp(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit adder: d (0..9) plus a carry-in of 0..18.
// Yields the digit result and a decimal carry of 0..2.
import score_pkg::*;

module bcd_digit_add (
  input  logic [3:0] d,
  input  logic [4:0] cin,
  output logic [3:0] q,
  output logic [1:0] cout
);

  logic [4:0] s;
  logic [4:0] r;

  assign s = {1'b0, d} + cin;

  always_comb begin
    r    = s;
    cout = 2'd0;
    if (s >= 5'd20) begin
      r    = s - 5'd20;
      cout = 2'd2;
    end else if (s >= 5'd10) begin
      r    = s - 5'd10;
      cout = 2'd1;
    end
  end

  assign q = r[3:0];

endmodule

// File: rtl/bcd_score_counter.sv
// N-digit packed-BCD game score counter with RUN/OVER control.
// Optional high-score tracking is built when SCORE_HISCORE_EN is defined.
import score_pkg::*;

module bcd_score_counter #(
  parameter int DIGITS    = 4,
  parameter int TICK_INC  = 1,
  parameter int WRAP_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                game_start,
  input  logic                game_over,
  input  logic                game_tick,
  input  logic                bonus_valid,
  input  logic [3:0]          bonus_amt,
  output logic [4*DIGITS-1:0] score,
  output logic                active,
  output logic                overflow,
  output logic [4*DIGITS-1:0] hiscore,
  output logic                new_hiscore
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL9 = {DIGITS{BCD_MAX}};

  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   score_q;
  logic [W-1:0]   sum;
  logic           ovf_q;
  logic           sat_q;
  logic [4:0]     addend;
  logic [4:0]     carry [DIGITS+1];
  logic [1:0]     cout  [DIGITS];
  logic           run_upd;
  logic           over_acc;
  logic           carry_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    priority case (1'b1)
      game_start:                     state_d = S_RUN;
      game_over && state_q == S_RUN:  state_d = S_OVER;
      default: ;
    endcase
  end

  assign run_upd  = state_q == S_RUN && !game_start && !game_over;
  assign over_acc = state_q == S_RUN && !game_start && game_over;

  assign addend = (game_tick ? 5'(TICK_INC) : 5'd0)
                + (bonus_valid ? {1'b0, bcd_clamp(bonus_amt)} : 5'd0);

  assign carry[0] = addend;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_add u_add (
      .d    (score_q[4*i +: 4]),
      .cin  (carry[i]),
      .q    (sum[4*i +: 4]),
      .cout (cout[i])
    );
    assign carry[i+1] = {3'b000, cout[i]};
  end

  assign carry_out = carry[DIGITS] != 5'd0;

  // Saturation pulses only once per game; sat_q remembers it has fired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
      ovf_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      if (game_start) begin
        score_q <= '0;
        sat_q   <= 1'b0;
      end else if (run_upd) begin
        if (!carry_out) begin
          score_q <= sum;
        end else if (WRAP_MODE != 0) begin
          score_q <= sum;
          ovf_q   <= 1'b1;
        end else begin
          score_q <= ALL9;
          ovf_q   <= !sat_q;
          sat_q   <= 1'b1;
        end
      end
    end
  end

  assign score    = score_q;
  assign active   = state_q == S_RUN;
  assign overflow = ovf_q;

`ifdef SCORE_HISCORE_EN
  logic [W-1:0] hi_q;
  logic         nh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      nh_q <= 1'b0;
    end else begin
      nh_q <= 1'b0;
      if (over_acc && score_q > hi_q) begin
        hi_q <= score_q;
        nh_q <= 1'b1;
      end
    end
  end

  assign hiscore     = hi_q;
  assign new_hiscore = nh_q;
`else
  logic unused_over;
  assign unused_over = over_acc;
  assign hiscore     = '0;
  assign new_hiscore = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_score_counter.sv
// Scoreboard bench for bcd_score_counter: saturating and wrapping
// instances share stimulus; a monitor checks each cycle against a model.
module tb_bcd_score_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        game_start = 1'b0;
  logic        game_over = 1'b0;
  logic        game_tick = 1'b0;
  logic        bonus_valid = 1'b0;
  logic [3:0]  bonus_amt = 4'd0;
  logic [15:0] score0, score1, hi0, hi1;
  logic        act0, act1, ovf0, ovf1, nh0, nh1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_score_counter #(.DIGITS(4), .TICK_INC(1), .WRAP_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .game_start(game_start),
    .game_over(game_over), .game_tick(game_tick),
    .bonus_valid(bonus_valid), .bonus_amt(bonus_amt),
    .score(score0), .active(act0), .overflow(ovf0),
    .hiscore(hi0), .new_hiscore(nh0)
  );

  bcd_score_counter #(.DIGITS(4), .TICK_INC(1), .WRAP_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .game_start(game_start),
    .game_over(game_over), .game_tick(game_tick),
    .bonus_valid(bonus_valid), .bonus_amt(bonus_amt),
    .score(score1), .active(act1), .overflow(ovf1),
    .hiscore(hi1), .new_hiscore(nh1)
  );

  typedef struct {
    logic [15:0] s0;
    logic [15:0] s1;
    logic [15:0] hi;
    logic        act;
    logic        o0;
    logic        o1;
    logic        nh;
  } exp_t;

  exp_t q[$];

  // Decimal reference model
  int m_st = 0;
  int m_s0 = 0;
  int m_s1 = 0;
  int m_hi = 0;
  bit m_sat = 0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic void chk(input string nm, input logic [15:0] act,
                              input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit hi_en();
`ifdef SCORE_HISCORE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("score_sat",   score0, e.s0);
      chk("score_wrap",  score1, e.s1);
      chk("active",      16'(act0), 16'(e.act));
      chk("active_wrap", 16'(act1), 16'(e.act));
      chk("ovf_sat",     16'(ovf0), 16'(e.o0));
      chk("ovf_wrap",    16'(ovf1), 16'(e.o1));
      chk("hiscore",     hi0, e.hi);
      chk("new_hi",      16'(nh0), 16'(e.nh));
    end
  end

  task automatic step(input logic st, input logic ov, input logic tk,
                      input logic bv, input logic [3:0] ba);
    exp_t e;
    int a;
    @(negedge clk);
    game_start  = st;
    game_over   = ov;
    game_tick   = tk;
    bonus_valid = bv;
    bonus_amt   = ba;
    e.o0 = 1'b0;
    e.o1 = 1'b0;
    e.nh = 1'b0;
    if (st) begin
      m_st = 1; m_s0 = 0; m_s1 = 0; m_sat = 0;
    end else if (ov) begin
      if (m_st == 1) begin
        m_st = 2;
        if (hi_en() && m_s0 > m_hi) begin
          m_hi = m_s0;
          e.nh = 1'b1;
        end
      end
    end else if (m_st == 1) begin
      a = (tk ? 1 : 0) + (bv ? ((ba > 9) ? 9 : int'(ba)) : 0);
      if (m_s0 + a > 9999) begin
        m_s0 = 9999;
        e.o0 = !m_sat;
        m_sat = 1;
      end else begin
        m_s0 = m_s0 + a;
      end
      if (m_s1 + a > 9999) begin
        m_s1 = m_s1 + a - 10000;
        e.o1 = 1'b1;
      end else begin
        m_s1 = m_s1 + a;
      end
    end
    e.s0  = to_bcd(m_s0);
    e.s1  = to_bcd(m_s1);
    e.hi  = to_bcd(m_hi);
    e.act = (m_st == 1);
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 4'd0);
  endtask

  task automatic advance(input int target);
    int d;
    while (m_s0 < target) begin
      d = target - m_s0;
      if (d >= 10)     step(0, 0, 1, 1, 4'd9);
      else if (d == 1) step(0, 0, 1, 0, 4'd0);
      else             step(0, 0, 0, 1, 4'(d));
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_score", score0, 16'h0000);
    chk("rst_active", 16'(act0), 16'h0000);
    chk("rst_hiscore", hi0, 16'h0000);
    chk("rst_ovf", 16'(ovf0), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    m_st = 0; m_s0 = 0; m_s1 = 0; m_hi = 0; m_sat = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int oc;
    #3;
    chk("por_score", score0, 16'h0000);
    chk("por_active", 16'(act0), 16'h0000);
    chk("por_hi", hi0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle: ticks and over ignored
    step(0, 0, 1, 1, 4'd5);
    step(0, 1, 0, 0, 4'd0);

    // 25 ticks then over
    step(1, 0, 0, 0, 4'd0);
    repeat (25) step(0, 0, 1, 0, 4'd0);
    #2 chk("t1_score", score0, 16'h0025);
    chk("t1_active", 16'(act0), 16'h0001);
    step(0, 1, 0, 0, 4'd0);
    idle();
    step(0, 0, 1, 0, 4'd0);
    #2 chk("t1_held", score0, 16'h0025);

    // 99 + tick + bonus 9
    step(1, 0, 0, 0, 4'd0);
    advance(99);
    step(0, 0, 1, 1, 4'd9);
    #2 chk("t2_score", score0, 16'h0109);

    // start+over, then over+tick
    step(1, 1, 0, 0, 4'd0);
    #2 chk("t4_start_active", 16'(act0), 16'h0001);
    chk("t4_start_score", score0, 16'h0000);
    advance(42);
    step(0, 1, 1, 0, 4'd0);
    #2 chk("t4_over_score", score0, 16'h0042);
    chk("t4_over_active", 16'(act0), 16'h0000);

    // Hiscore: 150 then 120
    async_reset();
    step(1, 0, 0, 0, 4'd0);
    advance(150);
    step(0, 1, 0, 0, 4'd0);
    #2 chk("t5_hi1", hi0, hi_en() ? 16'h0150 : 16'h0000);
    chk("t5_nh1", 16'(nh0), 16'(hi_en()));
    step(1, 0, 0, 0, 4'd0);
    #2 chk("t5_restart_hi", hi0, hi_en() ? 16'h0150 : 16'h0000);
    advance(120);
    step(0, 1, 0, 0, 4'd0);
    #2 chk("t5_hi2", hi0, hi_en() ? 16'h0150 : 16'h0000);
    chk("t5_nh2", 16'(nh0), 16'h0000);

    // Overflow: 9998 + 3 ticks
    step(1, 0, 0, 0, 4'd0);
    advance(9998);
    oc = 0;
    step(0, 0, 1, 0, 4'd0);
    #2 oc += int'(ovf0);
    chk("t3_wrap_a", score1, 16'h9999);
    chk("t3_wrap_a_ovf", 16'(ovf1), 16'h0000);
    step(0, 0, 1, 0, 4'd0);
    #2 oc += int'(ovf0);
    chk("t3_wrap_b", score1, 16'h0000);
    chk("t3_wrap_b_ovf", 16'(ovf1), 16'h0001);
    step(0, 0, 1, 0, 4'd0);
    #2 oc += int'(ovf0);
    chk("t3_wrap_c", score1, 16'h0001);
    chk("t3_wrap_c_ovf", 16'(ovf1), 16'h0000);
    chk("t3_sat_score", score0, 16'h9999);
    chk("t3_sat_pulses", 16'(oc), 16'h0001);
    repeat (2) step(0, 0, 1, 1, 4'd9);

    // Reset mid-run at 777, then clamped bonus
    step(1, 0, 0, 0, 4'd0);
    advance(777);
    async_reset();
    step(1, 0, 0, 0, 4'd0);
    step(0, 0, 0, 1, 4'hF);
    #2 chk("t6_clamp", score0, 16'h0009);
    step(0, 0, 1, 1, 4'd9);
    step(0, 0, 0, 0, 4'd0);
    #2 chk("t6_carry", score0, 16'h0019);

    repeat (3) @(posedge clk);
    #2 chk("queue_drained", 16'(q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
